// File: rtl/r0_alu_exec_pkg.sv
// Shared definitions for the r0 execute stage: opcodes, FSM state encoding
// and default datapath sizing.
package r0_alu_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int MUL_STEPS_DEF = 8;

    typedef logic [2:0] op_t;

    localparam op_t OP_ADD = 3'b000;
    localparam op_t OP_SUB = 3'b001;
    localparam op_t OP_AND = 3'b010;
    localparam op_t OP_OR  = 3'b011;
    localparam op_t OP_XOR = 3'b100;
    localparam op_t OP_MUL = 3'b101;
    localparam op_t OP_SHL = 3'b110;
    localparam op_t OP_SHR = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_MUL  = 2'b10;

    // MUL is the only opcode that takes the iterative path
    function automatic logic is_mul(input op_t op);
        return (op == OP_MUL);
    endfunction

endpackage

// File: rtl/r0_alu_exec_if.sv
// Operand/result bundle between r0_multiplexer, the execute stage and the
// writeback stage.
interface r0_alu_exec_if
    import r0_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             ready;
    op_t              op;
    logic [WIDTH-1:0] value1;
    logic [WIDTH-1:0] value2;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             carry;
    logic             neg;
    logic             busy;
    logic             done;
    logic             overrun;

    modport master (
        output ready, op, value1, value2,
        input  result_lo, result_hi, zero, carry, neg, busy, done, overrun
    );

    modport slave (
        input  ready, op, value1, value2,
        output result_lo, result_hi, zero, carry, neg, busy, done, overrun
    );

endinterface

// File: rtl/r0_alu_exec_mul.sv
// Iterative shift-add multiplier: multiplier in the low half of the
// accumulator, partial product shifting in from the top, one bit per step.
module r0_mul8_shift_add
    import r0_alu_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MUL_STEPS = MUL_STEPS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [3:0]         cnt_r;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] acc_next_s;

    // Conditional add of the multiplicand into the upper half, then shift right
    always_comb begin
        sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        acc_next_s = acc_r;
        if (acc_r[0]) begin
            sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
        end else begin
            sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        acc_next_s = {sum_s, acc_r[WIDTH-1:1]};
    end

    // The final step's product is exposed combinationally so the caller can
    // register it on the same edge the last iteration completes.
    assign done    = step && (cnt_r == 4'(MUL_STEPS - 1));
    assign product = acc_next_s;

    // Accumulator, multiplicand and step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= '0;
            mcand_r <= '0;
            cnt_r   <= 4'd0;
        end else if (start) begin
            acc_r   <= {{WIDTH{1'b0}}, b};
            mcand_r <= a;
            cnt_r   <= 4'd0;
        end else if (step) begin
            acc_r   <= acc_next_s;
            cnt_r   <= cnt_r + 4'd1;
        end else begin
            acc_r   <= acc_r;
            mcand_r <= mcand_r;
            cnt_r   <= cnt_r;
        end
    end

endmodule

// File: rtl/r0_alu_exec.sv
// Execute stage behind r0_multiplexer: captures an operand pair on a rising
// ready, runs one ALU op (MUL iteratively) and presents registered results.
module r0_alu_exec
    import r0_alu_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MUL_STEPS = MUL_STEPS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    r0_alu_exec_if.slave        bus
);

    logic [1:0]         state_r;
    logic               ready_q_r;
    op_t                op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   result_lo_r;
    logic [WIDTH-1:0]   result_hi_r;
    logic               zero_r;
    logic               carry_r;
    logic               neg_r;
    logic               busy_r;
    logic               done_r;
    logic               overrun_r;

    logic               accept_s;
    logic               mul_start_s;
    logic               mul_step_s;
    logic               mul_done_s;
    logic [2*WIDTH-1:0] mul_product_s;
    logic [WIDTH:0]     alu_s;

    // Held-high ready yields a single capture
    assign accept_s    = en & bus.ready & ~ready_q_r;
    assign mul_start_s = (state_r == ST_IDLE) && accept_s && is_mul(bus.op);
    assign mul_step_s  = (state_r == ST_MUL);

    r0_mul8_shift_add #(
        .WIDTH     (WIDTH),
        .MUL_STEPS (MUL_STEPS)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start_s),
        .step    (mul_step_s),
        .a       (bus.value1),
        .b       (bus.value2),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Single-cycle ops on the latched operands; MSB carries carry/borrow/shift-out
    always_comb begin
        alu_s = '0;
        case (op_r)
            OP_ADD:  alu_s = {1'b0, a_r} + {1'b0, b_r};
            OP_SUB:  alu_s = {1'b0, a_r} - {1'b0, b_r};
            OP_AND:  alu_s = {1'b0, a_r & b_r};
            OP_OR:   alu_s = {1'b0, a_r | b_r};
            OP_XOR:  alu_s = {1'b0, a_r ^ b_r};
            OP_SHL:  alu_s = {a_r[WIDTH-1], a_r[WIDTH-2:0], 1'b0};
            OP_SHR:  alu_s = {a_r[0], 1'b0, a_r[WIDTH-1:1]};
            default: alu_s = '0;
        endcase
    end

    // Edge-detect history for ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q_r <= 1'b0;
        end else begin
            ready_q_r <= bus.ready;
        end
    end

    // A capture attempt while an op is in flight is lost; flag it until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else if (accept_s && (state_r != ST_IDLE)) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    // Sequencer plus operand, result and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_ADD;
            a_r         <= '0;
            b_r         <= '0;
            result_lo_r <= '0;
            result_hi_r <= '0;
            zero_r      <= 1'b0;
            carry_r     <= 1'b0;
            neg_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r    <= bus.op;
                        a_r     <= bus.value1;
                        b_r     <= bus.value2;
                        busy_r  <= 1'b1;
                        state_r <= is_mul(bus.op) ? ST_MUL : ST_EXEC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    result_lo_r <= alu_s[WIDTH-1:0];
                    result_hi_r <= '0;
                    zero_r      <= (alu_s[WIDTH-1:0] == '0);
                    carry_r     <= alu_s[WIDTH];
                    neg_r       <= alu_s[WIDTH-1];
                    done_r      <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                ST_MUL: begin
                    if (mul_done_s) begin
                        result_lo_r <= mul_product_s[WIDTH-1:0];
                        result_hi_r <= mul_product_s[2*WIDTH-1:WIDTH];
                        zero_r      <= (mul_product_s == '0);
                        carry_r     <= (mul_product_s[2*WIDTH-1:WIDTH] != '0);
                        neg_r       <= mul_product_s[2*WIDTH-1];
                        done_r      <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_MUL;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.result_lo = result_lo_r;
    assign bus.result_hi = result_hi_r;
    assign bus.zero      = zero_r;
    assign bus.carry     = carry_r;
    assign bus.neg       = neg_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_r0_alu_exec.sv
// Self-checking bench for r0_alu_exec: directed corner cases then random ops
// compared against an arithmetic reference model.
module tb_r0_alu_exec;
    import r0_alu_pkg::*;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    // expected architectural state
    logic [7:0] e_lo, e_hi;
    logic       e_z, e_c, e_n, e_ovr;

    r0_alu_exec_if #(.WIDTH(W)) bus ();

    r0_alu_exec #(.WIDTH(W), .MUL_STEPS(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] out_vec();
        return {bus.result_hi, bus.result_lo, bus.zero, bus.carry, bus.neg,
                bus.busy, bus.done, bus.overrun};
    endfunction

    function automatic logic [21:0] exp_vec(input logic b, input logic d);
        return {e_hi, e_lo, e_z, e_c, e_n, b, d, e_ovr};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // reference: plain integer arithmetic on the opcode semantics
    task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        e_hi = 8'd0;
        case (op)
            3'd0: begin r = ia + ib;          e_c = (r > 255); end
            3'd1: begin r = ia - ib + 256;    e_c = (ia < ib); end
            3'd2: begin r = int'(a & b);      e_c = 1'b0;      end
            3'd3: begin r = int'(a | b);      e_c = 1'b0;      end
            3'd4: begin r = int'(a ^ b);      e_c = 1'b0;      end
            3'd5: begin r = ia * ib;          e_c = (r > 255); end
            3'd6: begin r = ia * 2;           e_c = (ia >= 128); end
            default: begin r = ia / 2;        e_c = (ia % 2 == 1); end
        endcase
        if (op == 3'd5) begin
            e_hi = 8'(r / 256);
            e_lo = 8'(r % 256);
            e_z  = (r == 0);
            e_n  = (r >= 32768);
        end else begin
            e_lo = 8'(r % 256);
            e_z  = (r % 256 == 0);
            e_n  = (r % 256 >= 128);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one transaction; poke_at raises ready again mid-flight, drop_en_at clears en
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int poke_at, input int drop_en_at, input string tag);
        int   cyc;
        logic seen;
        bus.ready  = 1'b1;
        bus.op     = op;
        bus.value1 = a;
        bus.value2 = b;
        tick();
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        bus.ready  = 1'b0;
        bus.op     = 3'($urandom);
        bus.value1 = 8'($urandom);
        bus.value2 = 8'($urandom);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            tick();
            cyc++;
            bus.ready = (cyc == poke_at);
            if (cyc == drop_en_at) en = 1'b0;
            seen = bus.done;
        end
        bus.ready = 1'b0;
        model(op, a, b);
        if (poke_at > 0) e_ovr = 1'b1;
        chk({tag, "_latency"}, cyc, (op == 3'd5) ? 32'd8 : 32'd1);
        chk({tag, "_outputs"}, {10'd0, out_vec()}, {10'd0, exp_vec(1'b0, 1'b1)});
        tick();
        chk({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int dones;
        bus.ready  = 1'b0;
        bus.op     = 3'd0;
        bus.value1 = 8'd0;
        bus.value2 = 8'd0;
        {e_lo, e_hi, e_z, e_c, e_n, e_ovr} = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {10'd0, out_vec()}, 32'd0);
        rst_n = 1'b1;
        tick();
        en = 1'b1;

        // directed arithmetic cases
        run_op(3'd0, 8'd200, 8'd100, 0, 0, "add_200_100");
        chk("add_lo_44", {24'd0, bus.result_lo}, 32'd44);
        chk("add_carry", {31'd0, bus.carry}, 32'd1);
        run_op(3'd1, 8'd1, 8'd2, 0, 0, "sub_1_2");
        chk("sub_lo_ff", {24'd0, bus.result_lo}, 32'hFF);
        run_op(3'd1, 8'd5, 8'd5, 0, 0, "sub_5_5");
        chk("sub_zero", {31'd0, bus.zero}, 32'd1);
        run_op(3'd5, 8'd15, 8'd17, 0, 0, "mul_15_17");
        chk("mul_255", {16'd0, bus.result_hi, bus.result_lo}, 32'd255);
        run_op(3'd5, 8'hFF, 8'hFF, 0, 0, "mul_ff_ff");
        chk("mul_fe01", {16'd0, bus.result_hi, bus.result_lo}, 32'hFE01);
        run_op(3'd6, 8'h81, 8'h00, 0, 0, "shl_81");
        run_op(3'd7, 8'h01, 8'hFF, 0, 0, "shr_01");

        // ready held high: single capture
        bus.ready  = 1'b1;
        bus.op     = 3'd0;
        bus.value1 = 8'd7;
        bus.value2 = 8'd9;
        dones = 0;
        repeat (5) begin tick(); dones += int'(bus.done); end
        bus.ready = 1'b0;
        repeat (4) begin tick(); dones += int'(bus.done); end
        model(3'd0, 8'd7, 8'd9);
        chk("held_ready_one_done", dones, 32'd1);
        chk("held_ready_outputs", {10'd0, out_vec()}, {10'd0, exp_vec(1'b0, 1'b0)});

        // ready rise during MUL: overrun, result intact
        run_op(3'd5, 8'd23, 8'd11, 3, 0, "mul_overrun");
        chk("overrun_set", {31'd0, bus.overrun}, 32'd1);

        // en low blocks capture
        en = 1'b0;
        bus.ready  = 1'b1;
        bus.op     = 3'd0;
        bus.value1 = 8'd1;
        bus.value2 = 8'd1;
        tick();
        bus.ready = 1'b0;
        dones = 0;
        repeat (10) begin tick(); dones += int'(bus.done); end
        chk("en_low_no_done", dones, 32'd0);
        chk("en_low_hold", {10'd0, out_vec()}, {10'd0, exp_vec(1'b0, 1'b0)});
        en = 1'b1;
        tick();

        // en dropped mid-MUL still completes
        run_op(3'd5, 8'd9, 8'd13, 0, 2, "mul_en_drop");
        en = 1'b1;
        tick();

        // reset in the middle of a MUL
        bus.ready  = 1'b1;
        bus.op     = 3'd5;
        bus.value1 = 8'hAB;
        bus.value2 = 8'hCD;
        tick();
        bus.ready = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midmul_reset_zero", {10'd0, out_vec()}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        dones = 0;
        repeat (10) begin tick(); dones += int'(bus.done); end
        chk("midmul_reset_no_done", dones, 32'd0);
        {e_lo, e_hi, e_z, e_c, e_n, e_ovr} = '0;
        chk("midmul_reset_hold", {10'd0, out_vec()}, 32'd0);
        run_op(3'd0, 8'd1, 8'd2, 0, 0, "add_after_reset");
        chk("add_after_reset_3", {24'd0, bus.result_lo}, 32'd3);

        // random ops against the model
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 0, 0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
